// File: rtl/kbd_pkg.sv
// Shared definitions for the keyboard event decoder.
//   kbd_state_e  : prefix-tracking FSM states
//   PFX_E0/PFX_F0: extended-key and break prefixes
//   DROP_BYTES   : keyboard response bytes that never become events
//   EV_W         : event word width {ext, brk, key[7:0]}
package kbd_pkg;

  localparam int EV_W = 10;

  localparam logic [7:0] PFX_E0 = 8'hE0;
  localparam logic [7:0] PFX_F0 = 8'hF0;

  // Self-test pass, ack, resend, echo, error/overrun bytes.
  localparam int N_DROP = 6;
  localparam logic [N_DROP*8-1:0] DROP_BYTES = {8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF};

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GOT_E0  = 2'd1,
    ST_GOT_F0  = 2'd2,
    ST_GOT_E0F0 = 2'd3
  } kbd_state_e;

  function automatic logic is_drop_byte(input logic [7:0] b);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < N_DROP; i++) begin
      if (b == DROP_BYTES[i*8 +: 8]) hit = 1'b1;
    end
    return hit;
  endfunction

endpackage

// File: rtl/kbd_event_if.sv
// Bus between the PS/2 byte source / event consumer and kbd_event.
//   code        : two-byte window, [7:0] newest byte
//   ev_pop      : consumer acknowledge for the head event
//   ev_valid    : event buffer non-empty
//   ev_data     : head event {ext, brk, key}
//   ev_overflow : sticky, an event was dropped on a full buffer
// master = source/consumer side, slave = kbd_event.
interface kbd_event_if;
  import kbd_pkg::*;

  logic [15:0]     code;
  logic            ev_pop;
  logic            ev_valid;
  logic [EV_W-1:0] ev_data;
  logic            ev_overflow;

  modport master (
    output code,
    output ev_pop,
    input  ev_valid,
    input  ev_data,
    input  ev_overflow
  );

  modport slave (
    input  code,
    input  ev_pop,
    output ev_valid,
    output ev_data,
    output ev_overflow
  );

endinterface

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO with sticky overflow flag.
//   clk, rst_n   : clock, async active-low reset
//   push_i/wdata_i : write request and data
//   pop_i        : remove head; ignored while empty
//   rdata_o      : head entry, valid whenever empty_o=0
//   empty_o, full_o
//   overflow_o   : sticky, set when a push is refused (full, no pop)
module sync_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             empty_o,
  output logic             full_o,
  output logic             overflow_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             overflow_q;
  logic             do_push, do_pop;

  assign empty_o    = (count_q == '0);
  assign full_o     = (count_q == (AW+1)'(DEPTH));
  assign rdata_o    = mem_q[rd_ptr_q];
  assign overflow_o = overflow_q;

  // A pop on the same edge frees the slot, so a full FIFO can still accept.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= wdata_i;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      if (push_i && !do_push) overflow_q <= 1'b1;
    end
  end

endmodule

// File: rtl/kbd_event.sv
// PS/2 scan-code to key-event decoder.
//   clk, rst_n : clock, async active-low reset
//   bus        : kbd_event_if.slave (code in, ev_pop in, ev_valid/ev_data/ev_overflow out)
// A new byte is any cycle where the code window differs from last cycle's.
// Prefix bytes E0/F0 are folded into the following key byte; the event is
// written into the FIFO on the same edge the key byte is detected.
//
// state       | meaning
// ------------+-------------------------------------------
// ST_IDLE     | no prefix pending
// ST_GOT_E0   | extended prefix seen
// ST_GOT_F0   | break prefix seen
// ST_GOT_E0F0 | extended break (E0 F0) seen
module kbd_event
  import kbd_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input logic         clk,
  input logic         rst_n,
  kbd_event_if.slave  bus
);

  logic [15:0]     code_prev_q;
  kbd_state_e      state_q, state_d;
  logic            new_byte;
  logic [7:0]      byte_in;
  logic            push;
  logic [EV_W-1:0] ev_d;
  logic            fifo_empty, fifo_full;

  assign new_byte = (bus.code != code_prev_q);
  assign byte_in  = bus.code[7:0];

  always_comb begin
    state_d = state_q;
    push    = 1'b0;
    ev_d    = {1'b0, 1'b0, byte_in};
    if (new_byte) begin
      if (byte_in == PFX_E0) begin
        // E0 always restarts an extended sequence, discarding a pending break.
        state_d = ST_GOT_E0;
      end else if (byte_in == PFX_F0) begin
        state_d = (state_q == ST_IDLE || state_q == ST_GOT_F0) ? ST_GOT_F0 : ST_GOT_E0F0;
      end else if (is_drop_byte(byte_in)) begin
        state_d = ST_IDLE;
      end else begin
        push    = 1'b1;
        ev_d    = {(state_q == ST_GOT_E0 || state_q == ST_GOT_E0F0),
                   (state_q == ST_GOT_F0 || state_q == ST_GOT_E0F0),
                   byte_in};
        state_d = ST_IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      code_prev_q <= 16'h0000;
    end else begin
      state_q     <= state_d;
      code_prev_q <= bus.code;
    end
  end

  sync_fifo #(
    .WIDTH (EV_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_i     (push),
    .wdata_i    (ev_d),
    .pop_i      (bus.ev_pop),
    .rdata_o    (bus.ev_data),
    .empty_o    (fifo_empty),
    .full_o     (fifo_full),
    .overflow_o (bus.ev_overflow)
  );

  assign bus.ev_valid = !fifo_empty;

  logic unused_full;
  assign unused_full = fifo_full;

endmodule

// File: tb/tb_kbd_event.sv
module tb_kbd_event;
  import kbd_pkg::*;

  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  kbd_event_if bus ();

  kbd_event #(.FIFO_DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: pending prefix flags plus a queue of events.
  logic [15:0] m_prev;
  bit          m_ext, m_brk, m_ovf;
  logic [9:0]  m_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_prev = 16'h0000;
    m_ext  = 0;
    m_brk  = 0;
    m_ovf  = 0;
    m_q.delete();
  endtask

  task automatic model_step(input logic [15:0] c, input logic p);
    bit pop_ok, full, have_ev;
    logic [7:0] b;
    logic [9:0] ev;
    pop_ok  = p && (m_q.size() > 0);
    full    = (m_q.size() == DEPTH);
    have_ev = 0;
    ev      = '0;
    if (c != m_prev) begin
      b = c[7:0];
      if (b == 8'hE0) begin
        m_ext = 1; m_brk = 0;
      end else if (b == 8'hF0) begin
        m_brk = 1;
      end else if (b inside {8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF}) begin
        m_ext = 0; m_brk = 0;
      end else begin
        have_ev = 1;
        ev = {m_ext, m_brk, b};
        m_ext = 0; m_brk = 0;
      end
    end
    m_prev = c;
    if (pop_ok) void'(m_q.pop_front());
    if (have_ev) begin
      if (full && !pop_ok) m_ovf = 1;
      else m_q.push_back(ev);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".valid"}, 32'(bus.ev_valid), 32'(m_q.size() != 0));
    if (m_q.size() != 0) chk({tag, ".data"}, 32'(bus.ev_data), 32'(m_q[0]));
    chk({tag, ".ovf"}, 32'(bus.ev_overflow), 32'(m_ovf));
  endtask

  // Called at a falling edge: drive, advance model, sample at next falling edge.
  task automatic cycle(input logic [15:0] c, input logic p, input string tag);
    bus.code   = c;
    bus.ev_pop = p;
    model_step(c, p);
    @(negedge clk);
    check_all(tag);
  endtask

  task automatic apply_reset(input logic [15:0] c);
    rst_n      = 1'b0;
    bus.code   = c;
    bus.ev_pop = 1'b0;
    @(negedge clk);
    chk("rst.valid", 32'(bus.ev_valid), 32'd0);
    chk("rst.data", 32'(bus.ev_data), 32'd0);
    chk("rst.ovf", 32'(bus.ev_overflow), 32'd0);
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic logic [7:0] pick_byte();
    int sel;
    sel = int'($urandom_range(0, 9));
    case (sel)
      0, 1:    return 8'hE0;
      2:       return 8'hF0;
      3: begin
        case ($urandom_range(0, 5))
          0: return 8'hAA;
          1: return 8'hFA;
          2: return 8'hFE;
          3: return 8'hEE;
          4: return 8'h00;
          default: return 8'hFF;
        endcase
      end
      default: return 8'($urandom_range(0, 255));
    endcase
  endfunction

  initial begin
    logic [15:0] c;
    rst_n      = 1'b0;
    bus.code   = 16'h0000;
    bus.ev_pop = 1'b0;
    model_clear();
    @(negedge clk);
    apply_reset(16'h0000);

    // Single make code, one clock latency.
    cycle(16'h0000, 0, "mk0");
    cycle(16'h001C, 0, "mk1");
    chk("mk.valid", 32'(bus.ev_valid), 32'd1);
    chk("mk.data", 32'(bus.ev_data), 32'h01C);
    chk("mk.ovf", 32'(bus.ev_overflow), 32'd0);
    cycle(16'h001C, 1, "mk.pop");

    // Break code.
    cycle(16'h1CF0, 0, "brk0");
    chk("brk.noev", 32'(bus.ev_valid), 32'd0);
    cycle(16'hF01C, 0, "brk1");
    chk("brk.data", 32'(bus.ev_data), 32'h11C);
    cycle(16'hF01C, 1, "brk.pop");

    // Extended break, then extended make.
    cycle(16'h0000, 0, "xb0");
    cycle(16'h00E0, 0, "xb1");
    cycle(16'hE0F0, 0, "xb2");
    cycle(16'hF074, 0, "xb3");
    chk("xbrk.data", 32'(bus.ev_data), 32'h374);
    cycle(16'hF074, 1, "xb.pop");
    cycle(16'h74E0, 0, "xm0");
    cycle(16'hE075, 0, "xm1");
    chk("xmk.data", 32'(bus.ev_data), 32'h275);
    cycle(16'hE075, 1, "xm.pop");

    // Overflow and pop-while-full.
    apply_reset(16'h0000);
    cycle(16'h0016, 0, "of1");
    cycle(16'h161E, 0, "of2");
    cycle(16'h1E26, 0, "of3");
    cycle(16'h2625, 0, "of4");
    chk("of.ovf4", 32'(bus.ev_overflow), 32'd0);
    cycle(16'h252E, 0, "of5");
    chk("of.ovf5", 32'(bus.ev_overflow), 32'd1);
    chk("of.head5", 32'(bus.ev_data), 32'h016);
    cycle(16'h2E36, 1, "of6");
    chk("of.head6", 32'(bus.ev_data), 32'h01E);
    for (int i = 0; i < 5; i++) cycle(16'h2E36, 1, "of.drain");
    chk("of.empty", 32'(bus.ev_valid), 32'd0);

    // Reset mid-prefix discards the pending E0.
    apply_reset(16'h0000);
    cycle(16'h00E0, 0, "rp0");
    apply_reset(16'h0000);
    cycle(16'h0000, 0, "rp1");
    chk("rp.noev", 32'(bus.ev_valid), 32'd0);
    cycle(16'h0029, 0, "rp2");
    chk("rp.data", 32'(bus.ev_data), 32'h029);
    cycle(16'h0029, 1, "rp.pop");

    // Response bytes dropped in IDLE and after a prefix.
    cycle(16'h29AA, 0, "dr0");
    cycle(16'hAAE0, 0, "dr1");
    cycle(16'hE0FA, 0, "dr2");
    chk("dr.noev", 32'(bus.ev_valid), 32'd0);
    cycle(16'hFA1C, 0, "dr3");
    chk("dr.data", 32'(bus.ev_data), 32'h01C);

    // Random byte streams with random pops and repeated windows.
    c = bus.code;
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) begin
        apply_reset(c);
      end
      if ($urandom_range(0, 3) != 0) c = {c[7:0], pick_byte()};
      cycle(c, 1'($urandom_range(0, 2) == 0), "rnd");
    end
    for (int i = 0; i < DEPTH + 1; i++) cycle(c, 1, "fin");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/kbd_event.md
KBD_EVENT -- requirements
Module: kbd_event

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, number of buffered key events (power of two, >= 2).
REQ-002 clk  input  1  system clock; all state on rising edge.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 code  input  16  two-byte window from the PS/2 receiver; code[7:0] newest byte, code[15:8] previous byte.
REQ-005 ev_pop  input  1  consumer acknowledge; removes head event when ev_valid=1.
REQ-006 ev_valid  output  1  FIFO non-empty; ev_data holds the head event.
REQ-007 ev_data  output  10  {ext, brk, key[7:0]}: ext=E0-prefixed, brk=release (F0-prefixed), key=scan code.
REQ-008 ev_overflow  output  1  sticky flag, an event was dropped on a full FIFO.

Function
REQ-009 Byte detection: register code_prev; new byte = code[7:0] in any cycle where code != code_prev; code_prev <= code every cycle.
REQ-010 Identical consecutive code windows (e.g. third byte of a 1C 1C 1C repeat) produce no new byte; this loss is specified behaviour.
REQ-011 Prefix FSM states: IDLE, GOT_E0, GOT_F0, GOT_E0F0; state changes only on a new byte.
REQ-012 IDLE: E0 -> GOT_E0; F0 -> GOT_F0; AA, FA, FE, EE, 00, FF dropped, stay IDLE; other -> emit {0,0,byte}, stay IDLE.
REQ-013 GOT_E0: F0 -> GOT_E0F0; E0 -> stay; other -> emit {1,0,byte}, -> IDLE.
REQ-014 GOT_F0: E0 -> GOT_E0; F0 -> stay; other -> emit {0,1,byte}, -> IDLE.
REQ-015 GOT_E0F0: E0 -> GOT_E0; F0 -> stay; other -> emit {1,1,byte}, -> IDLE.
REQ-016 Prefix states also drop AA/FA/FE/EE/00/FF and return to IDLE with no event.
REQ-017 Emission writes the FIFO on the same edge the new byte is detected; ev_valid rises one clk after the first cycle code holds the new value.
REQ-018 FIFO is show-ahead: ev_data valid whenever ev_valid=1; ev_data is don't-care and held when empty.
REQ-019 Pop with ev_valid=1 advances head on that edge; pop while empty is ignored.
REQ-020 Push while full and no pop: event dropped, ev_overflow set; FIFO contents unchanged.
REQ-021 Push and pop on the same edge while full: both occur, count unchanged, no overflow.
REQ-022 Push and pop on the same edge while empty: push only.
REQ-023 ev_overflow clears only on reset.
REQ-024 Pointers wrap modulo FIFO_DEPTH; occupancy counter is log2(FIFO_DEPTH)+1 bits wide.

Reset
REQ-025 rst_n low: code_prev=16'h0000, state=IDLE, FIFO empty, pointers=0, ev_valid=0, ev_data=0, ev_overflow=0.
REQ-026 Reset asserted mid-sequence discards pending prefix and buffered events; code=0 after release produces no event.

Structure
REQ-027 Package kbd_pkg holds the FSM state enum, prefix constants (E0, F0), the dropped-response byte list, and the event width (10).
REQ-028 Buffer is a sub-module sync_fifo (parameters WIDTH, DEPTH, async active-low reset, show-ahead); kbd_event holds change detection and the FSM.

Verification
REQ-029 Code sequence 0000->001C -> one event 0x01C, ev_valid one clk after change, ev_overflow=0.
REQ-030 001C->1CF0->F01C -> single event 0x11C (brk=1, ext=0); no event for F0.
REQ-031 0000->00E0->E0F0->F074 -> single event 0x374; E0 -> 75 -> event 0x275.
REQ-032 Six distinct make codes, no pop, FIFO_DEPTH=4 -> four events held in order, ev_overflow=1 after the fifth; pop on the full FIFO on the same edge as the sixth push -> count stays 4.
REQ-033 00E0 then rst_n pulse low mid-prefix, then 0000->0029 -> event 0x029 (ext=0); ev_valid=0 during reset.
REQ-034 Byte AA in IDLE and FA after E0 -> no events, state IDLE; following 1C -> 0x01C.
